// File: rtl/fetch_queue_stage_pkg.sv
// fetch_queue_stage_pkg: shared widths, reset PC and miss-FSM encoding for the fetch stage
package fetch_queue_stage_pkg;
  localparam int unsigned FQ_ADDR_W = 32;
  localparam int unsigned FQ_INST_W = 32;
  localparam int unsigned FQ_LINE_W = 128;
  localparam int unsigned FQ_QDEPTH = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_1000;
  localparam logic RUN = 1'b0;
  localparam logic MISS = 1'b1;
  typedef enum logic {S_RUN = RUN, S_MISS = MISS} fq_state_e;
endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_queue_stage_fifo: circular FIFO with flush; head reads as zero while empty
module fetch_queue_stage_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + {{AW{1'b0}}, do_push};
    rd_d = flush_i ? '0 : rd_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC, one-line L0 buffer and miss FSM feeding decode through a fetch queue
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = FQ_ADDR_W,
  parameter int unsigned INST_W = FQ_INST_W,
  parameter int unsigned LINE_W = FQ_LINE_W,
  parameter int unsigned QDEPTH = FQ_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_instr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [LINE_W-1:0] mem_line
);
  localparam int unsigned OFF = $clog2(LINE_W / 8);
  localparam int unsigned WSEL = $clog2(LINE_W / INST_W);
  localparam int unsigned NW = LINE_W / INST_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN = ~(STEP - 1'b1);
  fq_state_e st_q, st_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [ADDR_W-OFF-1:0] tag_q, tag_d;
  logic [NW-1:0][INST_W-1:0] l0_q, l0_d;
  logic l0v_q, l0v_d, req_q, req_d;
  logic hit, push, pop, full, empty;
  assign hit = l0v_q && tag_q == pc_q[ADDR_W-1:OFF];
  assign pop = out_ready && !empty;
  assign push = st_q == S_RUN && hit && !redirect_valid && (!full || pop);
  assign out_valid = !empty;
  assign mem_req = req_q;
  assign mem_addr = addr_q;
  // A redirect never cancels an outstanding miss; the returned line still fills L0.
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ALIGN) : (push ? pc_q + STEP : pc_q);
    st_d = st_q;
    req_d = req_q;
    addr_d = addr_q;
    tag_d = tag_q;
    l0_d = l0_q;
    l0v_d = l0v_q;
    if (st_q == S_RUN && !hit && !redirect_valid) begin
      st_d = S_MISS;
      req_d = 1'b1;
      addr_d = {pc_q[ADDR_W-1:OFF], {OFF{1'b0}}};
    end else if (st_q == S_MISS && mem_rdy) begin
      st_d = S_RUN;
      req_d = 1'b0;
      tag_d = addr_q[ADDR_W-1:OFF];
      l0_d = mem_line;
      l0v_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC & ALIGN;
      st_q <= S_RUN;
      req_q <= 1'b0;
      addr_q <= '0;
      tag_q <= '0;
      l0_q <= '0;
      l0v_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      st_q <= st_d;
      req_q <= req_d;
      addr_q <= addr_d;
      tag_q <= tag_d;
      l0_q <= l0_d;
      l0v_q <= l0v_d;
    end
  end
  fetch_queue_stage_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush_i(redirect_valid),
    .push_i(push),
    .pop_i(out_ready),
    .data_i({pc_q, l0_q[pc_q[OFF-1:OFF-WSEL]]}),
    .data_o({out_pc, out_instr}),
    .full_o(full),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed fetch scenarios checked against an output scoreboard
module tb_fetch_queue_stage;
  logic clk = 0, reset = 1, redirect_valid = 0, out_ready = 0, mem_rdy = 0;
  logic [31:0] redirect_pc = '0;
  logic [127:0] mem_line = '0;
  logic out_valid, mem_req;
  logic [31:0] out_pc, out_instr, mem_addr;
  int n_chk = 0, n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_line(mem_line)
  );

  function automatic logic [31:0] ins(input logic [31:0] a);
    return (a >> 2) - 32'h3F0;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = ins((a & 32'hFFFF_FFF0) + 32'(i * 4));
    return l;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a + 32'(i * 4), ins(a + 32'(i * 4))});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
      else step();
    end
    if (seen) chk("mem_addr", 64'(mem_addr), 64'(a));
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL mem_req_timeout: got mem_req=0 expected 1 for addr %h", a);
    end
  endtask

  task automatic serve(input logic [31:0] a, input int d);
    for (int i = 0; i < d; i++) begin
      step();
      @(negedge clk);
      chk("miss_hold", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, a});
    end
    step();
    mem_line = line_of(a);
    mem_rdy = 1;
    step();
    mem_rdy = 0;
    mem_line = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected: got pc=%h instr=%h expected none", out_pc, out_instr);
          end else begin
            exp_e = exp_q.pop_front();
            chk("out_pair", {out_pc, out_instr}, exp_e);
          end
        end
      end
    join_none
    // reset values, then first fill with decode always ready
    out_ready = 1;
    step();
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    step();
    reset = 0;
    wait_req(32'h1000);
    push_exp(32'h1000, 4);
    serve(32'h1000, 3);
    @(negedge clk);
    chk("lat_n1_valid", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    chk("lat_n2_valid", 64'(out_valid), 64'd1);
    chk("lat_n2_head", {out_pc, out_instr}, {32'h1000, 32'h10});
    wait_req(32'h1010);
    // back-pressure: queue fills to four, then one pop and one push together
    step();
    out_ready = 0;
    do_reset();
    wait_req(32'h1000);
    push_exp(32'h1000, 4);
    serve(32'h1000, 3);
    wait_req(32'h1010);
    chk("full_head", {out_pc, out_instr}, {32'h1000, 32'h10});
    push_exp(32'h1010, 1);
    serve(32'h1010, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_head", {31'b0, out_valid, out_pc}, {31'b0, 1'b1, 32'h1000});
      chk("stall_req", 64'(mem_req), 64'd0);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    step();
    out_ready = 0;
    @(negedge clk);
    chk("pop_push_head", {out_pc, out_instr}, {32'h1004, 32'h11});
    push_exp(32'h1014, 3);
    step();
    out_ready = 1;
    wait_req(32'h1020);
    repeat (6) step();
    chk("drain_full", 64'(exp_q.size()), 64'd0);
    // redirect into the L0 line while three entries are queued
    out_ready = 0;
    do_reset();
    wait_req(32'h1000);
    serve(32'h1000, 1);
    repeat (3) step();
    redirect_valid = 1;
    redirect_pc = 32'h1008;
    step();
    redirect_valid = 0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_req", 64'(mem_req), 64'd0);
    push_exp(32'h1008, 2);
    step();
    @(negedge clk);
    chk("redir_head", {out_pc, out_instr}, {32'h1008, 32'h12});
    chk("redir_noreq", 64'(mem_req), 64'd0);
    step();
    out_ready = 1;
    wait_req(32'h1010);
    // redirect during a miss keeps the request outstanding
    step();
    redirect_valid = 1;
    redirect_pc = 32'h2000;
    step();
    redirect_valid = 0;
    @(negedge clk);
    chk("redir_miss_hold", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h1010});
    serve(32'h1010, 2);
    wait_req(32'h2000);
    push_exp(32'h2000, 4);
    serve(32'h2000, 1);
    wait_req(32'h2010);
    repeat (3) step();
    chk("drain_2000", 64'(exp_q.size()), 64'd0);
    // reset mid-miss; a pulse arriving in RUN is ignored
    reset = 1;
    step();
    reset = 0;
    mem_rdy = 1;
    mem_line = '1;
    @(negedge clk);
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_addr", 64'(mem_addr), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    step();
    mem_rdy = 0;
    mem_line = '0;
    wait_req(32'h1000);
    push_exp(32'h1000, 4);
    serve(32'h1000, 2);
    wait_req(32'h1010);
    // top-of-address-space redirect and wrap to zero
    step();
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    serve(32'h1010, 1);
    wait_req(32'hFFFF_FFF0);
    push_exp(32'hFFFF_FFFC, 1);
    serve(32'hFFFF_FFF0, 2);
    wait_req(32'h0000_0000);
    push_exp(32'h0000_0000, 4);
    serve(32'h0000_0000, 1);
    wait_req(32'h0000_0010);
    repeat (3) step();
    chk("drain_wrap", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
